// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-primary Wishbone classic arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } wb_req_t;

  localparam int DefaultTimeoutCycles = 16;

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts stalled strobe cycles of the current owner and flags
// the cycle in which the stall limit is reached.
module wb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TimeoutCycles = DefaultTimeoutCycles
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic active,
  input  logic stb,
  input  logic ack,
  input  logic err,
  output logic tout
);

  localparam int TimerW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [TimerW-1:0] Limit = TimerW'(TimeoutCycles);

  logic [TimerW-1:0] timer_q, timer_d;

  // A real response in the limit cycle takes precedence over the forced error.
  assign tout = (TimeoutCycles != 0) && (timer_q == Limit) && !ack && !err;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    timer_d = timer_q;
    if (!active || ack || err || tout) begin
      timer_d = '0;
    end else if (stb && (TimeoutCycles != 0)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-primary, one-secondary Wishbone classic arbiter with locked grants,
// round-robin contention and a stall watchdog.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int TimeoutCycles = DefaultTimeoutCycles
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [3:0]  m0_sel,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [3:0]  m1_sel,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [3:0]  s_sel,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_ack,
  input  logic        s_err,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant_out
);

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;  // index of the primary that last owned the bus
  wb_req_t    req0, req1, s_req;
  logic       wd_active;
  logic       tout;

  assign req0 = {m0_cyc, m0_stb, m0_we, m0_sel, m0_addr, m0_wdata};
  assign req1 = {m1_cyc, m1_stb, m1_we, m1_sel, m1_addr, m1_wdata};

  // Ownership only changes once the owner drops cyc; contention favours
  // the primary that did not own the bus last.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          state_d = last_grant_q ? GNT0 : GNT1;
        end else if (m0_cyc) begin
          state_d = GNT0;
        end else if (m1_cyc) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc) begin
          last_grant_d = 1'b0;
          state_d      = m1_cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc) begin
          last_grant_d = 1'b1;
          state_d      = m0_cyc ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The timer restarts whenever ownership changes, including a direct handover.
  assign wd_active = (state_q != IDLE) && (state_d == state_q);

  wb_watchdog #(
    .TimeoutCycles(TimeoutCycles)
  ) u_watchdog (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .active  (wd_active),
    .stb     (s_req.stb),
    .ack     (s_ack),
    .err     (s_err),
    .tout    (tout)
  );

  always_comb begin
    s_req     = '0;
    m0_ack    = 1'b0;
    m0_err    = 1'b0;
    m0_rdata  = '0;
    m1_ack    = 1'b0;
    m1_err    = 1'b0;
    m1_rdata  = '0;
    grant_out = 2'b00;
    case (state_q)
      GNT0: begin
        s_req     = req0;
        m0_ack    = s_ack;
        m0_err    = s_err | tout;
        m0_rdata  = s_rdata;
        grant_out = 2'b01;
      end
      GNT1: begin
        s_req     = req1;
        m1_ack    = s_ack;
        m1_err    = s_err | tout;
        m1_rdata  = s_rdata;
        grant_out = 2'b10;
      end
      default: ;
    endcase
  end

  // The timed-out strobe is withdrawn so a late secondary cannot complete it.
  assign s_cyc   = s_req.cyc;
  assign s_stb   = s_req.stb & ~tout;
  assign s_we    = s_req.we;
  assign s_sel   = s_req.sel;
  assign s_addr  = s_req.addr;
  assign s_wdata = s_req.wdata;

  // NOTE: the asynchronous reset returns to IDLE, which forces every output low at once.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: directed scenarios plus randomized
// traffic compared against a transaction-level ownership model.
module tb_wb_arbiter2;

  localparam int Tout = 16;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_cyc, s_stb, s_we, s_ack, s_err;
  logic [3:0]  s_sel;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  grant_out;

  int checks = 0;
  int errors = 0;

  wire [140:0] all_out = {s_cyc, s_stb, s_we, s_sel, s_addr, s_wdata,
                          m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata, grant_out};

  wb_arbiter2 #(.TimeoutCycles(Tout)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_sel(s_sel),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_err(s_err), .s_rdata(s_rdata),
    .grant_out(grant_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0; m0_addr = 0; m0_wdata = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0; m1_addr = 0; m1_wdata = 0;
    s_ack = 0; s_err = 0; s_rdata = 32'hCAFE_0001;
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk_in); #1;
  endtask

  task automatic sample();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 reset_in = 1'b1;
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    clear_inputs();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; s_ack = 1; s_err = 1;
    repeat (2) @(posedge clk_in);
    sample();
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    do_reset();
    sample();
    checks++;
    if (grant_out !== 2'b00) begin
      errors++; $display("FAIL reset_idle_grant: got %b want 00", grant_out);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    next_cycle();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
    m0_addr = 32'h0000_4000; m0_wdata = 32'h5;
    sample();
    checks++;
    if ({s_cyc, grant_out} !== 3'b000) begin
      errors++; $display("FAIL single_latency: got s_cyc=%b grant=%b want 0/00", s_cyc, grant_out);
    end
    next_cycle();
    sample();
    checks++;
    if ({s_cyc, s_stb, s_we, s_sel, s_addr, s_wdata, grant_out, m0_ack} !==
        {3'b111, 4'hF, 32'h0000_4000, 32'h5, 2'b01, 1'b0}) begin
      errors++; $display("FAIL single_route: got cyc=%b stb=%b we=%b sel=%h addr=%h wdata=%h grant=%b ack=%b",
                         s_cyc, s_stb, s_we, s_sel, s_addr, s_wdata, grant_out, m0_ack);
    end
    next_cycle();
    s_ack = 1; s_rdata = 32'h1234_5678;
    sample();
    checks++;
    if ({m0_ack, m0_err, m0_rdata, m1_ack, m1_rdata} !== {2'b10, 32'h1234_5678, 1'b0, 32'h0}) begin
      errors++; $display("FAIL single_ack: got m0_ack=%b m0_err=%b m0_rdata=%h m1_ack=%b m1_rdata=%h",
                         m0_ack, m0_err, m0_rdata, m1_ack, m1_rdata);
    end
    next_cycle();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    sample();
    checks++;
    if ({s_cyc, m0_ack, grant_out} !== 4'b0001) begin
      errors++; $display("FAIL single_drop: got s_cyc=%b ack=%b grant=%b want 0/0/01", s_cyc, m0_ack, grant_out);
    end
    next_cycle();
    sample();
    checks++;
    if (grant_out !== 2'b00) begin
      errors++; $display("FAIL single_idle: got grant=%b want 00", grant_out);
    end
  endtask

  task automatic test_contention();
    do_reset();
    next_cycle();
    m0_cyc = 1; m1_cyc = 1;
    m0_addr = 32'hA0; m1_addr = 32'hB0;
    next_cycle();
    sample();
    checks++;
    if ({grant_out, s_addr} !== {2'b01, 32'hA0}) begin
      errors++; $display("FAIL contend_first: got grant=%b addr=%h want 01/a0", grant_out, s_addr);
    end
    next_cycle();
    m0_cyc = 0;
    sample();
    checks++;
    if ({grant_out, s_cyc} !== 3'b010) begin
      errors++; $display("FAIL contend_drop: got grant=%b s_cyc=%b want 01/0", grant_out, s_cyc);
    end
    next_cycle();
    sample();
    checks++;
    if ({grant_out, s_cyc, s_addr} !== {3'b101, 32'hB0}) begin
      errors++; $display("FAIL contend_handover: got grant=%b s_cyc=%b addr=%h want 10/1/b0", grant_out, s_cyc, s_addr);
    end
  endtask

  task automatic test_lock();
    int acks = 0;
    do_reset();
    next_cycle();
    m1_cyc = 1;
    next_cycle();
    m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      m1_stb = (i % 2 == 0); s_ack = (i % 2 == 0);
      sample();
      if (m1_ack === 1'b1) acks++;
      checks++;
      if ({grant_out, m0_ack} !== 3'b100) begin
        errors++; $display("FAIL lock_hold[%0d]: got grant=%b m0_ack=%b want 10/0", i, grant_out, m0_ack);
      end
    end
    checks++;
    if (acks !== 3) begin
      errors++; $display("FAIL lock_ack_count: got %0d want 3", acks);
    end
    next_cycle();
    m1_stb = 0; s_ack = 0; m1_cyc = 0;
    sample();
    checks++;
    if ({grant_out, s_cyc} !== 3'b100) begin
      errors++; $display("FAIL lock_release: got grant=%b s_cyc=%b want 10/0", grant_out, s_cyc);
    end
    next_cycle();
    sample();
    checks++;
    if ({grant_out, s_cyc, s_stb} !== 4'b0111) begin
      errors++; $display("FAIL lock_next_owner: got grant=%b cyc=%b stb=%b want 01/1/1", grant_out, s_cyc, s_stb);
    end
  endtask

  // ack_at_limit: the secondary answers in the cycle the watchdog would fire.
  task automatic test_timeout(input bit ack_at_limit);
    do_reset();
    s_rdata = 32'hDEAD_BEEF;
    next_cycle();
    m0_cyc = 1;
    next_cycle();
    m0_stb = 1;
    for (int k = 0; k <= Tout + 1; k++) begin
      if (k > 0) next_cycle();
      s_ack = ack_at_limit && (k == Tout);
      sample();
      checks++;
      if (k == Tout && !ack_at_limit) begin
        if ({m0_err, m0_ack, s_stb, s_cyc, m1_ack, m1_err, m1_rdata} !== {4'b1001, 2'b00, 32'h0}) begin
          errors++; $display("FAIL timeout_fire: got err=%b ack=%b s_stb=%b s_cyc=%b m1=%b/%b/%h",
                             m0_err, m0_ack, s_stb, s_cyc, m1_ack, m1_err, m1_rdata);
        end
      end else if (k == Tout) begin
        if ({m0_ack, m0_err, s_stb} !== 3'b101) begin
          errors++; $display("FAIL timeout_ack_wins: got ack=%b err=%b s_stb=%b want 1/0/1", m0_ack, m0_err, s_stb);
        end
      end else if ({m0_err, m0_ack, s_stb} !== 3'b001) begin
        errors++; $display("FAIL timeout_wait[%0d]: got err=%b ack=%b s_stb=%b want 0/0/1", k, m0_err, m0_ack, s_stb);
      end
    end
  endtask

  task automatic test_reset_mid_cycle();
    do_reset();
    next_cycle();
    m1_cyc = 1; m1_stb = 1;
    next_cycle();
    sample();
    checks++;
    if ({grant_out, s_stb} !== 3'b101) begin
      errors++; $display("FAIL rstmid_pre: got grant=%b s_stb=%b want 10/1", grant_out, s_stb);
    end
    next_cycle();
    #2 reset_in = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL rstmid_async: got %h want 0", all_out);
    end
    next_cycle();
    reset_in = 1'b1; m0_cyc = 1;
    sample();
    checks++;
    if (grant_out !== 2'b00) begin
      errors++; $display("FAIL rstmid_idle: got grant=%b want 00", grant_out);
    end
    next_cycle();
    sample();
    checks++;
    if (grant_out !== 2'b01) begin
      errors++; $display("FAIL rstmid_m0_first: got grant=%b want 01", grant_out);
    end
  endtask

  // Model: who owns the bus, who owned it last, and how long the owner has stalled.
  task automatic test_random();
    int owner = -1, last = 1, stall = 0, nxt;
    int ack_pct;
    int pct_tab[4] = '{2, 10, 40, 80};
    bit c[2], st[2], w[2];
    logic [3:0] sl[2];
    logic [31:0] ad[2], wd[2];
    bit sa, se, to;
    logic [31:0] srd;
    logic [140:0] exp_v;
    bit e_ack[2], e_err[2];
    logic [31:0] e_rd[2];
    logic [1:0] e_gnt;
    logic [70:0] e_req;
    do_reset();
    c = '{0, 0};
    for (int n = 0; n < 2000; n++) begin
      next_cycle();
      if (n % 250 == 0) ack_pct = pct_tab[$urandom_range(0, 3)];
      for (int i = 0; i < 2; i++) begin
        c[i]  = c[i] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
        st[i] = c[i] && ($urandom_range(0, 9) < 7);
        w[i]  = 1'($urandom);
        sl[i] = 4'($urandom);
        ad[i] = $urandom;
        wd[i] = $urandom;
      end
      sa  = ($urandom_range(0, 99) < ack_pct);
      se  = ($urandom_range(0, 99) < 2);
      srd = $urandom;
      m0_cyc = c[0]; m0_stb = st[0]; m0_we = w[0]; m0_sel = sl[0]; m0_addr = ad[0]; m0_wdata = wd[0];
      m1_cyc = c[1]; m1_stb = st[1]; m1_we = w[1]; m1_sel = sl[1]; m1_addr = ad[1]; m1_wdata = wd[1];
      s_ack = sa; s_err = se; s_rdata = srd;
      sample();

      to = (owner >= 0) && (stall == Tout) && !sa && !se;
      e_ack = '{0, 0}; e_err = '{0, 0}; e_rd = '{32'h0, 32'h0};
      e_gnt = 2'b00; e_req = '0;
      if (owner >= 0) begin
        e_req = {c[owner], st[owner] && !to, w[owner], sl[owner], ad[owner], wd[owner]};
        e_ack[owner] = sa;
        e_err[owner] = se || to;
        e_rd[owner]  = srd;
        e_gnt = (owner == 0) ? 2'b01 : 2'b10;
      end
      exp_v = {e_req, e_ack[0], e_err[0], e_rd[0], e_ack[1], e_err[1], e_rd[1], e_gnt};
      checks++;
      if (all_out !== exp_v) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", n, all_out, exp_v);
      end

      nxt = owner;
      if (owner < 0) begin
        if (c[0] && c[1]) nxt = 1 - last;
        else if (c[0])    nxt = 0;
        else if (c[1])    nxt = 1;
      end else if (!c[owner]) begin
        last = owner;
        nxt  = c[1 - owner] ? 1 - owner : -1;
      end
      if (owner >= 0 && nxt == owner) begin
        if (sa || se || to) stall = 0;
        else if (st[owner]) stall++;
      end else begin
        stall = 0;
      end
      owner = nxt;
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_lock();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_cycle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
